// File: rtl/beep_tone_gen_if.sv
// Buzzer back-end bundle: requested tone in, square wave and status out.
interface beep_tone_gen_if #(
  parameter int FREQ_W = 11,
  parameter int CNT_W  = 25
);
  logic [FREQ_W-1:0] frequency;
  logic              beep;
  logic              active;
  logic              busy;
  logic [CNT_W-1:0]  half_period;

  // Sequencer side: supplies the tone, observes the generator
  modport master (
    output frequency,
    input  beep,
    input  active,
    input  busy,
    input  half_period
  );

  // Generator side
  modport slave (
    input  frequency,
    output beep,
    output active,
    output busy,
    output half_period
  );
endinterface

// File: rtl/beep_tone_gen.sv
// Buzzer tone generator: converts a frequency in Hz to a half-period count
// with a restoring divider, then toggles a 50%-duty square wave.
module beep_tone_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FREQ_W = 11,
  parameter int MIN_HZ = 20,
  parameter int CNT_W  = 25
) (
  input  logic           clk,
  input  logic           rst,
  beep_tone_gen_if.slave bus
);

  localparam int BC_W  = $clog2(CNT_W + 1);
  localparam int REM_W = FREQ_W + 1;
  localparam logic [CNT_W-1:0]  DIVIDEND = CNT_W'(CLK_HZ / 2);
  localparam logic [FREQ_W-1:0] MIN_F    = FREQ_W'(MIN_HZ);
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(CNT_W - 1);

  if (longint'(CLK_HZ / 2) >= (longint'(1) << CNT_W)) begin : g_width_check
    $error("CLK_HZ/2 does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {IDLE, DIVIDE, LOAD} state_t;

  state_t             state_q, state_d;
  logic               latch_req;
  logic               req_silent, cur_silent, load_silent;
  logic [FREQ_W-1:0]  freq_req, freq_q;
  logic [CNT_W-1:0]   quo, quotient;
  logic [REM_W-1:0]   rem, rem_next;
  logic [REM_W:0]     rem_shift, rem_diff;
  logic               q_bit;
  logic [BC_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]   counter, half_q;
  logic               beep_q, active_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; two silence codes are treated as the same request so
  // moving between them does not restart anything
  always_comb begin
    state_d    = state_q;
    latch_req  = 1'b0;
    req_silent = bus.frequency < MIN_F;
    cur_silent = freq_q < MIN_F;
    case (state_q)
      IDLE: begin
        if ((bus.frequency != freq_q) && !(req_silent && cur_silent)) begin
          latch_req = 1'b1;
          state_d   = req_silent ? LOAD : DIVIDE;
        end
      end
      DIVIDE:  if (bit_cnt == LAST_BIT) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring shift-subtract step; the borrow bit of the difference is
  // the inverted quotient bit
  always_comb begin
    rem_shift = {rem, quo[CNT_W-1]};
    rem_diff  = rem_shift - {2'b00, freq_req};
    q_bit     = ~rem_diff[REM_W];
    rem_next  = q_bit ? rem_diff[REM_W-1:0] : rem_shift[REM_W-1:0];
  end

  // Divider datapath: dividend shifts out of quo while quotient bits shift in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_req <= '0;
      quo      <= '0;
      rem      <= '0;
      bit_cnt  <= '0;
    end else if (latch_req) begin
      freq_req <= bus.frequency;
      quo      <= DIVIDEND;
      rem      <= '0;
      bit_cnt  <= '0;
    end else if (state_q == DIVIDE) begin
      quo     <= {quo[CNT_W-2:0], q_bit};
      rem     <= rem_next;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Load-time values: zero quotient clamps to one
  always_comb begin
    load_silent = freq_req < MIN_F;
    quotient    = (quo == '0) ? CNT_W'(1) : quo;
  end

  // Tone generator and load of the new half-period; a tonal load keeps the
  // current beep level so the first half-cycle is never a runt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q   <= '0;
      half_q   <= '0;
      counter  <= '0;
      active_q <= 1'b0;
      beep_q   <= 1'b0;
    end else if (state_q == LOAD) begin
      freq_q   <= freq_req;
      half_q   <= load_silent ? '0 : quotient;
      counter  <= '0;
      active_q <= !load_silent;
      if (load_silent) beep_q <= 1'b0;
    end else if (active_q) begin
      if (counter == half_q - 1'b1) begin
        counter <= '0;
        beep_q  <= ~beep_q;
      end else begin
        counter <= counter + 1'b1;
      end
    end else begin
      counter <= '0;
      beep_q  <= 1'b0;
    end
  end

  assign bus.beep        = beep_q;
  assign bus.active      = active_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.half_period = half_q;

endmodule

// File: tb/tb_beep_tone_gen.sv
// Bench for beep_tone_gen: full-size build plus a small-clock build.
module tb_beep_tone_gen;

  logic clk = 1'b0;
  logic rst, rst_s;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  beep_tone_gen_if #(.FREQ_W(11), .CNT_W(25)) m_if ();
  beep_tone_gen_if #(.FREQ_W(11), .CNT_W(19)) s_if ();

  beep_tone_gen #(.CLK_HZ(50_000_000), .FREQ_W(11), .MIN_HZ(20), .CNT_W(25)) u_main (
    .clk (clk), .rst (rst), .bus (m_if.slave));

  beep_tone_gen #(.CLK_HZ(1_000_000), .FREQ_W(11), .MIN_HZ(20), .CNT_W(19)) u_small (
    .clk (clk), .rst (rst_s), .bus (s_if.slave));

  typedef struct {
    int freq;
    int lat;
    int half;
    int act;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_m(output int n);
    n = 0;
    do begin tick(); n++; end while (m_if.busy && n < 60);
  endtask

  task automatic wait_idle_s(output int n);
    n = 0;
    do begin tick(); n++; end while (s_if.busy && n < 60);
  endtask

  // Expected half-period from the rule: floor((clk/2)/f), clamped to 1, 0 if silent
  function automatic int ref_half(input int f, input int clk_hz);
    int q;
    if (f < 20) return 0;
    q = (clk_hz / 2) / f;
    return (q == 0) ? 1 : q;
  endfunction

  initial begin
    int n;
    int loaded[$];
    logic [24:0] prev;
    int m_q, m_H, m_b0, m_t;

    vecs[0] = '{262,  27, 95419, 1};
    vecs[1] = '{1046, 27, 23900, 1};
    vecs[2] = '{2000, 27, 12500, 1};
    vecs[3] = '{2047, 27, 12212, 1};
    vecs[4] = '{19,   2,  0,     0};
    vecs[5] = '{659,  27, 37936, 1};
    vecs[6] = '{1,    2,  0,     0};

    rst = 1'b1; rst_s = 1'b1;
    m_if.frequency = '0; s_if.frequency = '0;
    tick(); tick();
    check("rst_beep", m_if.beep, 0);
    check("rst_active", m_if.active, 0);
    check("rst_busy", m_if.busy, 0);
    check("rst_half", m_if.half_period, 0);
    rst = 1'b0; rst_s = 1'b0;
    repeat (3) tick();
    check("idle_busy", m_if.busy, 0);

    // 1000 Hz: latency, value, and one measured period
    m_if.frequency = 11'd1000;
    wait_idle_m(n);
    check("f1000_lat", n, 27);
    check("f1000_half", m_if.half_period, 25000);
    check("f1000_active", m_if.active, 1);
    check("f1000_beep_start", m_if.beep, 0);
    n = 0;
    while (m_if.beep !== 1'b1 && n < 30000) begin tick(); n++; end
    check("f1000_low_time", n, 25000);
    n = 0;
    while (m_if.beep !== 1'b0 && n < 30000) begin tick(); n++; end
    check("f1000_high_time", n, 25000);
    repeat (10) tick();
    check("same_value_busy", m_if.busy, 0);

    for (int i = 0; i < 7; i++) begin
      m_if.frequency = 11'(vecs[i].freq);
      wait_idle_m(n);
      check($sformatf("vec%0d_f%0d_lat", i, vecs[i].freq), n, vecs[i].lat);
      check($sformatf("vec%0d_f%0d_half", i, vecs[i].freq), m_if.half_period, vecs[i].half);
      check($sformatf("vec%0d_f%0d_active", i, vecs[i].freq), m_if.active, vecs[i].act);
      if (vecs[i].act == 0) check($sformatf("vec%0d_beep", i), m_if.beep, 0);
    end

    // 1 -> 0: both silence, no restart
    m_if.frequency = 11'd0;
    n = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (m_if.busy) n++; end
    check("silence_swap_busy", n, 0);
    check("silence_swap_half", m_if.half_period, 0);

    // Changes during a divide: 523 completes, 587 skipped, 784 ends loaded
    m_if.frequency = 11'd523;
    repeat (5) tick();
    m_if.frequency = 11'd587;
    repeat (3) tick();
    m_if.frequency = 11'd784;
    prev = m_if.half_period;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (m_if.half_period != prev) begin
        loaded.push_back(int'(m_if.half_period));
        prev = m_if.half_period;
      end
    end
    check("skip_count", loaded.size(), 2);
    check("skip_first", loaded.size() > 0 ? loaded[0] : -1, 47801);
    check("skip_last", loaded.size() > 1 ? loaded[1] : -1, 31887);
    check("skip_busy", m_if.busy, 0);

    // Reset mid-divide, outputs drop before the next edge
    m_if.frequency = 11'd440;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_div_busy", m_if.busy, 0);
    check("rst_div_active", m_if.active, 0);
    check("rst_div_half", m_if.half_period, 0);
    check("rst_div_beep", m_if.beep, 0);
    #2 rst = 1'b0;
    wait_idle_m(n);
    check("f440_lat", n, 27);
    check("f440_half", m_if.half_period, 56818);
    check("f440_active", m_if.active, 1);
    repeat (100) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_tone_active", m_if.active, 0);
    check("rst_tone_half", m_if.half_period, 0);
    #2 rst = 1'b0;
    m_if.frequency = '0;

    // Small-clock build
    s_if.frequency = 11'd2047;
    wait_idle_s(n);
    check("s2047_lat", n, 21);
    check("s2047_half", s_if.half_period, 244);
    s_if.frequency = 11'd19;
    wait_idle_s(n);
    check("s19_lat", n, 2);
    check("s19_half", s_if.half_period, 0);
    check("s19_active", s_if.active, 0);
    s_if.frequency = 11'd20;
    wait_idle_s(n);
    check("s20_lat", n, 21);
    check("s20_half", s_if.half_period, 25000);
    check("s20_active", s_if.active, 1);
    s_if.frequency = 11'd2047;
    wait_idle_s(n);
    n = 0;
    while (s_if.beep !== 1'b1 && n < 600) begin tick(); n++; end
    check("s_beep_high", s_if.beep, 1);
    #2 rst_s = 1'b1;
    #1;
    check("s_rst_beep", s_if.beep, 0);
    check("s_rst_active", s_if.active, 0);
    check("s_rst_half", s_if.half_period, 0);

    // Randomized run against the waveform model
    s_if.frequency = '0;
    tick();
    rst_s = 1'b0;
    m_q = 0; m_H = 0; m_b0 = 0; m_t = 0;
    for (int it = 0; it < 16; it++) begin
      int f, r, lat, hold, exp_beep;
      bit restart;
      r = $urandom_range(0, 7);
      if (r == 0)      f = m_q;
      else if (r == 1) f = $urandom_range(0, 19);
      else if (r <= 3) f = $urandom_range(17, 23);
      else             f = $urandom_range(20, 2047);
      restart = (f != m_q) && !(f < 20 && m_q < 20);
      lat = !restart ? 0 : (f < 20 ? 2 : 21);
      hold = $urandom_range(30, 600);
      s_if.frequency = 11'(f);
      for (int c = 1; c <= lat + hold; c++) begin
        tick();
        if (restart && c == lat) begin
          m_b0 = (f < 20 || m_H == 0) ? 0 : (m_b0 ^ ((m_t / m_H) & 1));
          m_H = ref_half(f, 1_000_000);
          m_q = f;
          m_t = 0;
        end else begin
          m_t++;
        end
        exp_beep = (m_H == 0) ? 0 : (m_b0 ^ ((m_t / m_H) & 1));
        check($sformatf("rnd%0d_f%0d_c%0d_beep", it, f, c), s_if.beep, exp_beep);
        check($sformatf("rnd%0d_f%0d_c%0d_half", it, f, c), s_if.half_period, m_H);
        check($sformatf("rnd%0d_f%0d_c%0d_active", it, f, c), s_if.active, (m_H != 0) ? 1 : 0);
        check($sformatf("rnd%0d_f%0d_c%0d_busy", it, f, c), s_if.busy, (restart && c < lat) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/beep_tone_gen.md
Name: beep_tone_gen

Overview:
- Back end of the buzzer path. Consumes the 11-bit `frequency` word (Hz) produced by the BGM/effect sequencers and drives a 50%-duty square wave to the piezo buzzer pin.
- Converts Hz to a half-period count with an iterative divider, then toggles the output on a free-running counter.
- Values below MIN_HZ (including the sequencers' `silence`=1 code) mute the output.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz
- FREQ_W, 11, width of the frequency input
- MIN_HZ, 20, lowest audible value; any input below it is silence
- CNT_W, 25, width of the half-period and counter datapath; must hold CLK_HZ/2

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- frequency  input  FREQ_W  requested tone in Hz; 0..MIN_HZ-1 = silence
- beep  output  1  square wave to the buzzer driver
- active  output  1  high while a non-silent tone is loaded
- busy  output  1  high while a divide/load is in progress
- half_period  output  CNT_W  currently loaded half-period in clk cycles; 0 when silent

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: beep=0, active=0, busy=0, half_period=0, counter=0, freq_q=0, FSM=IDLE.
- FSM states: IDLE, DIVIDE, LOAD.
- IDLE:
  - If frequency != freq_q: latch freq_req=frequency, then
  - if freq_req < MIN_HZ, go to LOAD with result 0 (no divide);
  - otherwise go to DIVIDE.
  - busy=0 only in IDLE.
- DIVIDE:
  - Restoring shift-subtract of constant CLK_HZ/2 by freq_req, one quotient bit per cycle, exactly CNT_W cycles.
  - Quotient is truncated (floor).
  - If the quotient is 0, it is clamped to 1.
- LOAD (1 cycle):
  - freq_q<=freq_req, half_period<=quotient (or 0), counter<=0, active<=(freq_req>=MIN_HZ).
  - If silent, beep<=0. If not silent, beep keeps its current level.
  - Return to IDLE.
- Latency: from a frequency change to the new half_period is CNT_W+2 cycles when tonal, 2 cycles when silent.
- Frequency changes during DIVIDE/LOAD are not aborted. The current request completes. The next IDLE cycle compares frequency against the new freq_q and restarts if they differ. Intermediate values may therefore be skipped; only the last stable value matters.
- Tone generation, when active=1:
  - When counter == half_period-1: counter<=0 and beep toggles.
  - Otherwise counter increments.
  - Full period = 2*half_period cycles, duty exactly 50%.
- When active=0, counter holds at 0 and beep=0.
- Same value re-presented: no restart, no phase disturbance.
- A new tonal value restarts the counter from 0 without forcing beep low, so there is no runt pulse shorter than one half-period.
- Width rules:
  - CLK_HZ/2 must fit CNT_W (elaboration-time check).
  - Quotient ≤ CLK_HZ/(2*MIN_HZ) fits CNT_W.
  - frequency is zero-extended to CNT_W for the subtract.
- Reset mid-DIVIDE: everything returns to reset values immediately. After release, the first IDLE cycle re-evaluates frequency, since freq_q=0.
- frequency=0 and frequency=1 are both silence. The 2047 maximum is legal.

Test Plan:
- Reset, then frequency=1000 held → busy high 27 cycles, then half_period=25000, active=1; beep period measured at 50000 cycles, high time 25000.
- frequency=262 → half_period=95419. frequency=1046 → 23900. frequency=2000 → 12500. Each is loaded CNT_W+2 cycles after the change.
- Tone playing at 659, then frequency=1 → within 2 cycles active=0, beep=0, half_period=0. Then frequency=0 → no restart, busy stays 0.
- During DIVIDE for 523, frequency changes to 587 and then 784 → 523 loads first, then one restart, and 784 is finally loaded. The 587 request is never loaded.
- rst pulsed mid-DIVIDE and mid-tone → outputs 0 asynchronously (before next clk edge). After release with frequency=440 held, half_period=56818 after CNT_W+2 cycles.
- Small-clock build with CLK_HZ=1_000_000, CNT_W=19: frequency=2047 → half_period=244. frequency=19 → silence. frequency=20 → half_period=25000.
